// File: rtl/eth_pkg.sv
// -----------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the switch egress/ingress framing FSMs.
//
// The port FIFO carries 34-bit words:
//   [31:0] payload data
//   [32]   SOP, first word of a frame
//   [33]   EOP, last word of a frame
// The receive FSM writes this format and the transmit FSM reads it, so both
// import these definitions to keep the bit layout in one place.
// -----------------------------------------------------------------------------
package eth_pkg;

   localparam int unsigned DATA_W      = 32;
   localparam int unsigned SOP_BIT     = 32;
   localparam int unsigned EOP_BIT     = 33;
   localparam int unsigned FIFO_WORD_W = 34;

   // Widest legal inter-frame gap is 15, so 4 bits hold any gap count.
   localparam int unsigned IFG_CNT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XMIT = 2'd1,
      GAP  = 2'd2
   } xmt_state_t;

   // Field order matches the FIFO bit layout: eop is bit 33, sop is bit 32.
   typedef struct packed {
      logic              eop;
      logic              sop;
      logic [DATA_W-1:0] data;
   } fifo_word_t;

   // Reinterpret a raw FIFO read word as its fields.
   function automatic fifo_word_t unpack_word(input logic [FIFO_WORD_W-1:0] raw);
      return fifo_word_t'(raw);
   endfunction

endpackage

// File: rtl/eth_ifg_timer.sv
// -----------------------------------------------------------------------------
// eth_ifg_timer
// Inter-frame gap down-counter for the transmit FSM.
//
// Ports:
//   clk     clock
//   reset   synchronous, active-low reset
//   load_i  pulse when an EOP beat is launched; reloads the gap count
//   done_o  high when the next frame may start reading from the FIFO
//
// The counter is loaded with IFG_CYCLES on the edge that launches the EOP beat,
// so it reads IFG_CYCLES during the EOP beat cycle and counts down by one per
// cycle after that, stopping at zero.
// -----------------------------------------------------------------------------
import eth_pkg::*;

module eth_ifg_timer #(
   parameter int unsigned IFG_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   output logic done_o
);

   logic [IFG_CNT_W-1:0] cnt_q;
   logic [IFG_CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = IFG_CNT_W'(IFG_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - IFG_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A read issued now returns next cycle and becomes a beat the cycle after,
   // so reading may resume once only one idle cycle is still owed.
   assign done_o = (cnt_q <= IFG_CNT_W'(1));

endmodule

// File: rtl/eth_xmt_fsm.sv
// -----------------------------------------------------------------------------
// eth_xmt_fsm
// Transmit-side framing FSM for one switch egress port.
//
// Pulls 34-bit words from the port FIFO (1-cycle registered read) and launches
// them as registered beats on the egress bus with SOP/EOP/valid strobes.
// Enforces a minimum inter-frame gap, idles through FIFO underrun mid-frame,
// drops words that arrive outside a frame and flags truncated frames.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-low reset
//   fifoEmpty   port FIFO empty flag
//   fifoData    FIFO read data, valid the cycle after rdEnable
//   rdEnable    FIFO read strobe (combinational)
//   outData     egress data, 0 when no beat
//   outSop      first beat of frame
//   outEop      last beat of frame
//   outValid    beat valid
//   txActive    high from the SOP beat through the EOP beat inclusive
//   frameCount  frames completed with a proper EOP, wraps silently
//   errDrop     one-cycle pulse: word discarded (no SOP while idle)
//   errTrunc    one-cycle pulse: open frame cut short by a new SOP
//
// Timing: rdEnable in cycle t -> word on fifoData in t+1 -> beat in t+2.
// -----------------------------------------------------------------------------
import eth_pkg::*;

module eth_xmt_fsm #(
   parameter int unsigned IFG_CYCLES = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fifoEmpty,
   input  logic [FIFO_WORD_W-1:0] fifoData,
   output logic                   rdEnable,
   output logic [DATA_W-1:0]      outData,
   output logic                   outSop,
   output logic                   outEop,
   output logic                   outValid,
   output logic                   txActive,
   output logic [CNT_W-1:0]       frameCount,
   output logic                   errDrop,
   output logic                   errTrunc
);

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   xmt_state_t          state_q, state_d;
   logic                rd_vld_q;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   logic                out_sop_q, out_sop_d;
   logic                out_eop_q, out_eop_d;
   logic                out_valid_q, out_valid_d;
   logic                tx_active_q, tx_active_d;
   logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
   logic                err_drop_q, err_drop_d;
   logic                err_trunc_q, err_trunc_d;

   fifo_word_t          word;
   logic                ifg_done;
   logic                ifg_load;
   logic                gap_block;
   logic                eop_return;

   // Beat decode of the returning word, shared by next-state and outputs.
   logic                beat_vld;
   logic                beat_sop;
   logic                beat_eop;
   logic                drop;
   logic                trunc;

   assign word = unpack_word(fifoData);

   // ---------------------------------------------------------------------------
   // Inter-frame gap timer
   // ---------------------------------------------------------------------------
   eth_ifg_timer #(
      .IFG_CYCLES (IFG_CYCLES)
   ) u_ifg_timer (
      .clk    (clk),
      .reset  (reset),
      .load_i (ifg_load),
      .done_o (ifg_done)
   );

   // ---------------------------------------------------------------------------
   // FIFO read strobe
   // ---------------------------------------------------------------------------
   assign gap_block  = (state_q == GAP) && !ifg_done;
   // Holding off while an EOP returns keeps the next frame's SOP behind the
   // gap timer, which is only loaded once that EOP is decoded.
   assign eop_return = rd_vld_q && word.eop;
   // Gated by reset so nothing is popped while the port is held in reset.
   assign rdEnable   = reset && !fifoEmpty && !gap_block && !eop_return;

   // ---------------------------------------------------------------------------
   // Next-state and beat decode
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      beat_vld = 1'b0;
      beat_sop = 1'b0;
      beat_eop = 1'b0;
      drop     = 1'b0;
      trunc    = 1'b0;

      if (rd_vld_q) begin
         unique case (state_q)
            // GAP never sees a returning word (reads are held until the gap
            // ends), but decoding it like IDLE keeps any such word framed.
            IDLE, GAP: begin
               if (word.sop) begin
                  beat_vld = 1'b1;
                  beat_sop = 1'b1;
                  beat_eop = word.eop;
                  state_d  = word.eop ? GAP : XMIT;
               end else begin
                  drop = 1'b1;
               end
            end
            XMIT: begin
               beat_vld = 1'b1;
               beat_sop = word.sop;
               beat_eop = word.eop;
               trunc    = word.sop;
               if (word.eop) begin
                  state_d = GAP;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if ((state_q == GAP) && ifg_done) begin
         state_d = IDLE;
      end
   end

   assign ifg_load = beat_eop;

   // ---------------------------------------------------------------------------
   // Output next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      out_valid_d = beat_vld;
      out_sop_d   = beat_sop;
      out_eop_d   = beat_eop;
      out_data_d  = beat_vld ? word.data : '0;
      // Covers the EOP beat itself, where the FSM is already heading to GAP.
      tx_active_d = beat_vld || (state_d == XMIT);
      err_drop_d  = drop;
      err_trunc_d = trunc;
      frame_cnt_d = frame_cnt_q;
      if (beat_eop) begin
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         rd_vld_q    <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_valid_q <= 1'b0;
         tx_active_q <= 1'b0;
         frame_cnt_q <= '0;
         err_drop_q  <= 1'b0;
         err_trunc_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_vld_q    <= rdEnable;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_valid_q <= out_valid_d;
         tx_active_q <= tx_active_d;
         frame_cnt_q <= frame_cnt_d;
         err_drop_q  <= err_drop_d;
         err_trunc_q <= err_trunc_d;
      end
   end

   assign outData    = out_data_q;
   assign outSop     = out_sop_q;
   assign outEop     = out_eop_q;
   assign outValid   = out_valid_q;
   assign txActive   = tx_active_q;
   assign frameCount = frame_cnt_q;
   assign errDrop    = err_drop_q;
   assign errTrunc   = err_trunc_q;

endmodule

// File: tb/tb_eth_xmt_fsm.sv
// -----------------------------------------------------------------------------
// tb_eth_xmt_fsm
// Self-checking bench for eth_xmt_fsm. A queue models the port FIFO; every
// popped word is classified by the framing rules (in frame or not, SOP/EOP)
// into an expected effect due two cycles later, and one compare process checks
// all outputs against those effects every cycle. Directed cases pin the model
// with literal values; a randomized run covers the rest.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_eth_xmt_fsm;

   localparam int unsigned IFG = 3;
   localparam int unsigned CW  = 4;   // narrow counter so the random run wraps it

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           fifoEmpty = 1'b1;
   logic [33:0]    fifoData = '0;
   logic           rdEnable;
   logic [31:0]    outData;
   logic           outSop, outEop, outValid, txActive;
   logic [CW-1:0]  frameCount;
   logic           errDrop, errTrunc;

   eth_xmt_fsm #(
      .IFG_CYCLES (IFG),
      .CNT_W      (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifoEmpty  (fifoEmpty),
      .fifoData   (fifoData),
      .rdEnable   (rdEnable),
      .outData    (outData),
      .outSop     (outSop),
      .outEop     (outEop),
      .outValid   (outValid),
      .txActive   (txActive),
      .frameCount (frameCount),
      .errDrop    (errDrop),
      .errTrunc   (errTrunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic        beat;
      logic [31:0] data;
      logic        sop;
      logic        eop;
      logic        drop;
      logic        trunc;
      int          cnt;
      logic        act;
   } eff_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        sop;
      logic        eop;
   } obs_t;

   logic [33:0] fifo_q[$];
   eff_t        pend_q[$];
   obs_t        log_q[$];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   block_until = -100;  // last cycle in which no read may be issued
   logic in_frame = 1'b0;
   int   mcnt = 0;
   int   cur_cnt = 0;
   logic cur_act = 1'b0;
   int   drops_seen = 0;
   int   truncs_seen = 0;
   int   pops = 0;
   logic started = 1'b0;
   logic stall = 1'b0;
   logic rd_s = 1'b0;
   eff_t ce;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Framing rules applied to one popped word; read issued in cycle t.
   task automatic model(input logic [33:0] w, input int t);
      eff_t e;
      e.due = t + 2; e.beat = 1'b0; e.data = '0; e.sop = 1'b0; e.eop = 1'b0;
      e.drop = 1'b0; e.trunc = 1'b0;
      if (!in_frame && !w[32]) begin
         e.drop = 1'b1;
         if (w[33]) block_until = t + 1;
      end else begin
         e.beat = 1'b1; e.data = w[31:0]; e.sop = w[32]; e.eop = w[33];
         e.trunc = in_frame && w[32];
         if (w[33]) begin
            mcnt = (mcnt + 1) % (1 << CW);
            in_frame = 1'b0;
            block_until = t + int'(IFG);
         end else begin
            in_frame = 1'b1;
         end
      end
      e.cnt = mcnt;
      e.act = in_frame;
      pend_q.push_back(e);
   endtask

   task automatic upd_empty();
      fifoEmpty = stall || (fifo_q.size() == 0);
   endtask

   task automatic push(input logic sop, input logic eop, input logic [31:0] d);
      fifo_q.push_back({eop, sop, d});
      upd_empty();
   endtask

   task automatic set_stall(input logic v);
      stall = v;
      upd_empty();
   endtask

   task automatic step();
      logic [33:0] w;
      logic        got;
      got = 1'b0;
      w   = '0;
      @(posedge clk);
      if (!reset) begin
         fifo_q.delete(); in_frame = 1'b0; mcnt = 0; block_until = -100;
      end else if (rd_s && fifo_q.size() > 0) begin
         w = fifo_q.pop_front();
         got = 1'b1;
         pops++;
         model(w, cyc);
      end
      #1;
      // Junk on the read bus whenever no read returns.
      fifoData = got ? w : {2'($urandom_range(0, 3)), 32'($urandom)};
      upd_empty();
   endtask

   task automatic drain();
      int g;
      g = 0;
      while ((fifo_q.size() != 0 || pend_q.size() != 0) && g < 400) begin
         step();
         g++;
      end
      chk("drain_done", 64'(g < 400), 64'(1));
      step();
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (started) begin
         ce.beat = 1'b0; ce.data = '0; ce.sop = 1'b0; ce.eop = 1'b0;
         ce.drop = 1'b0; ce.trunc = 1'b0;
         if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            ce = pend_q.pop_front();
            cur_cnt = ce.cnt;
            cur_act = ce.act;
         end
         chk("outValid", 64'(outValid), 64'(ce.beat));
         chk("outSop", 64'(outSop), 64'(ce.sop));
         chk("outEop", 64'(outEop), 64'(ce.eop));
         chk("outData", 64'(outData), 64'(ce.data));
         chk("errDrop", 64'(errDrop), 64'(ce.drop));
         chk("errTrunc", 64'(errTrunc), 64'(ce.trunc));
         chk("txActive", 64'(txActive), 64'(ce.beat | cur_act));
         chk("frameCount", 64'(frameCount), 64'(cur_cnt));
         if (reset) begin
            chk("rdEnable", 64'(rdEnable), 64'(!fifoEmpty && (cyc > block_until)));
         end
         if (outValid) log_q.push_back('{cyc, outData, outSop, outEop});
         if (errDrop) drops_seen++;
         if (errTrunc) truncs_seen++;
         if (!reset) begin
            pend_q.delete();
            cur_cnt = 0;
            cur_act = 1'b0;
         end
      end
      rd_s = rdEnable;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, t0, p0, d0, g, tr0;
      logic [31:0] exp_d [5];
      logic [33:0] src[$];
      int len;

      reset = 1'b0;
      step();
      started = 1'b1;
      step();
      step();
      chk("rst_outValid", 64'(outValid), 64'(0));
      chk("rst_frameCount", 64'(frameCount), 64'(0));
      reset = 1'b1;
      step();

      // Three-word frame: reads in t0..t0+2, beats in t0+2..t0+4.
      base = log_q.size();
      t0 = cyc;
      push(1'b1, 1'b0, 32'hAABBCCDD);
      push(1'b0, 1'b0, 32'h11223344);
      push(1'b0, 1'b1, 32'hDEADBEEF);
      drain();
      chk("t1_beats", 64'(log_q.size() - base), 64'(3));
      chk("t1_sop_cyc", 64'(log_q[base].cyc), 64'(t0 + 2));
      chk("t1_sop_data", 64'(log_q[base].data), 64'(32'hAABBCCDD));
      chk("t1_sop_flag", 64'(log_q[base].sop), 64'(1));
      chk("t1_eop_cyc", 64'(log_q[base+2].cyc), 64'(t0 + 4));
      chk("t1_eop_data", 64'(log_q[base+2].data), 64'(32'hDEADBEEF));
      chk("t1_eop_flag", 64'(log_q[base+2].eop), 64'(1));
      chk("t1_count", 64'(frameCount), 64'(1));

      // Two 4-word frames back to back: SOP exactly IFG+1 cycles after EOP.
      base = log_q.size();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 4; i++) push(i == 0, i == 3, 32'h2000_0000 + 32'(f * 16 + i));
      end
      drain();
      chk("t2_beats", 64'(log_q.size() - base), 64'(8));
      chk("t2_eop", 64'(log_q[base+3].eop), 64'(1));
      chk("t2_sop2", 64'(log_q[base+4].sop), 64'(1));
      chk("t2_gap", 64'(log_q[base+4].cyc - log_q[base+3].cyc), 64'(IFG + 1));
      chk("t2_count", 64'(frameCount), 64'(3));

      // Underrun: FIFO reports empty for 2 cycles after the 2nd word is read.
      base = log_q.size();
      p0 = pops;
      for (int i = 0; i < 5; i++) begin
         exp_d[i] = 32'h3000_0000 + 32'(i);
         push(i == 0, i == 4, exp_d[i]);
      end
      g = 0;
      while (pops < p0 + 2 && g < 50) begin step(); g++; end
      set_stall(1'b1);
      step();
      step();
      set_stall(1'b0);
      drain();
      chk("t3_beats", 64'(log_q.size() - base), 64'(5));
      chk("t3_span", 64'(log_q[base+4].cyc - log_q[base].cyc), 64'(6));
      for (int i = 0; i < 5; i++) chk("t3_order", 64'(log_q[base+i].data), 64'(exp_d[i]));
      chk("t3_count", 64'(frameCount), 64'(4));

      // Stray word while idle is dropped; the following frame goes out normally.
      base = log_q.size();
      d0 = drops_seen;
      push(1'b0, 1'b0, 32'h12345678);
      push(1'b1, 1'b0, 32'hCAFE0001);
      push(1'b0, 1'b1, 32'hCAFE0002);
      drain();
      chk("t4_drops", 64'(drops_seen - d0), 64'(1));
      chk("t4_beats", 64'(log_q.size() - base), 64'(2));
      chk("t4_first", 64'(log_q[base].data), 64'(32'hCAFE0001));
      chk("t4_count", 64'(frameCount), 64'(5));

      // SOP inside an open frame: truncation, only the final EOP counts.
      base = log_q.size();
      tr0 = truncs_seen;
      push(1'b1, 1'b0, 32'hA1);
      push(1'b0, 1'b0, 32'hA2);
      push(1'b1, 1'b0, 32'hB1);
      push(1'b0, 1'b0, 32'hB2);
      push(1'b0, 1'b1, 32'hB3);
      drain();
      chk("t5_truncs", 64'(truncs_seen - tr0), 64'(1));
      chk("t5_beats", 64'(log_q.size() - base), 64'(5));
      chk("t5_newsop", 64'(log_q[base+2].sop), 64'(1));
      chk("t5_count", 64'(frameCount), 64'(6));

      // Reset during the 2nd beat of a frame.
      base = log_q.size();
      for (int i = 0; i < 4; i++) push(i == 0, i == 3, 32'h5000_0000 + 32'(i));
      g = 0;
      while (log_q.size() < base + 1 && g < 50) begin step(); g++; end
      reset = 1'b0;
      step();
      chk("t6_valid", 64'(outValid), 64'(0));
      chk("t6_active", 64'(txActive), 64'(0));
      chk("t6_data", 64'(outData), 64'(0));
      chk("t6_count", 64'(frameCount), 64'(0));
      reset = 1'b1;
      for (int i = 0; i < 3; i++) push(i == 0, i == 2, 32'h6000_0000 + 32'(i));
      drain();
      chk("t6_after", 64'(frameCount), 64'(1));

      // Randomized frames, stray words, truncations and underruns.
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 7) == 0) src.push_back({1'($urandom_range(0, 1)), 1'b0, 32'($urandom)});
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            src.push_back({i == len - 1,
                           (i == 0) || ((i != len - 1) && ($urandom_range(0, 9) == 0)),
                           32'($urandom)});
         end
      end
      g = 0;
      while (src.size() > 0 && g < 5000) begin
         if ($urandom_range(0, 3) != 0) begin
            fifo_q.push_back(src.pop_front());
            if (src.size() > 0 && $urandom_range(0, 1) == 0) fifo_q.push_back(src.pop_front());
         end
         set_stall($urandom_range(0, 7) == 0);
         step();
         g++;
      end
      set_stall(1'b0);
      drain();
      chk("rand_count", 64'(frameCount), 64'(mcnt));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/eth_xmt_fsm.md
Name: eth_xmt_fsm

Overview:
Transmit-side framing FSM for one switch egress port. Reads 34-bit words from the port FIFO (bits 31:0 data, bit 32 SOP, bit 33 EOP) and drives the frame onto the egress data bus with explicit SOP/EOP/valid strobes. Enforces a minimum inter-frame gap, absorbs FIFO underrun mid-frame, and flags malformed FIFO content. It is the counterpart of the receive FSM that writes the same 34-bit word format into the FIFO.

Parameters:
IFG_CYCLES, 3, minimum idle output cycles between an EOP beat and the next SOP beat; legal range 1..15
CNT_W, 16, width of frame counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
fifoEmpty  in  1  port FIFO empty flag
fifoData  in  34  FIFO read data, valid the cycle after rdEnable (1-cycle registered read)
rdEnable  out  1  FIFO read strobe (combinational)
outData  out  32  egress data
outSop  out  1  first beat of frame (destination address)
outEop  out  1  last beat of frame
outValid  out  1  beat valid
txActive  out  1  high from SOP beat through EOP beat inclusive
frameCount  out  CNT_W  frames completed with a proper EOP, wraps modulo 2^CNT_W
errDrop  out  1  one-cycle pulse: word discarded
errTrunc  out  1  one-cycle pulse: frame truncated by unexpected SOP

Behaviour:
- Reset (reset==0 at posedge): outData, outSop, outEop, outValid, txActive, frameCount, errDrop, errTrunc = 0; state IDLE; read-in-flight flag cleared; IFG counter cleared. Reset takes effect mid-frame; any in-flight word is lost (FIFO is reset in the same cycle at system level).
- States: IDLE (no frame open), XMIT (SOP sent, awaiting EOP), GAP (IFG enforcement).
- rdVld register = rdEnable delayed one cycle; fifoData is sampled only when rdVld=1.
- rdEnable = !fifoEmpty AND state!=GAP-blocking AND NOT(rdVld AND fifoData[33]). No read is issued in the cycle an EOP word returns; at most one read in flight.
- Latency: rdEnable at cycle t -> beat on outputs at cycle t+2. Sustained throughput 1 word/cycle within a frame.
- All beat outputs registered; when no beat, outValid=outSop=outEop=0 and outData holds 0.
- IDLE: returned word with SOP -> output beat with outSop=1, txActive=1, go XMIT (or GAP if EOP also set: single-word frame, outSop=outEop=1, frameCount+1). Word without SOP -> not output, errDrop pulse, stay IDLE.
- XMIT: word without SOP/EOP -> output beat. Word with EOP -> output beat outEop=1, frameCount+1, go GAP. Word with SOP -> errTrunc pulse, word output as new SOP beat, stay XMIT, frameCount unchanged.
- Underrun: FIFO empty in XMIT -> outValid low for those cycles, state held, no timeout.
- GAP: if FIFO holds next frame, next SOP beat appears exactly at cycle E+IFG_CYCLES+1 where E is the EOP beat cycle (IFG_CYCLES idle cycles); later if FIFO empty. txActive low from E+1.
- errDrop/errTrunc asserted in the output-beat cycle of the offending word.
- frameCount wraps 0xFFFF -> 0x0000 without flag.

Decomposition:
- Package eth_pkg: SOP_BIT=32, EOP_BIT=33, FIFO_WORD_W=34, typedef enum logic [1:0] {IDLE, XMIT, GAP} xmt_state_t; shared with receive FSM.
- One sub-module: eth_ifg_timer (load IFG_CYCLES on EOP, down-count, done flag).

Test Plan:
- FIFO preloaded {SOP,0xAABBCCDD},{0,0x11223344},{EOP,0xDEADBEEF}, rdEnable cycles 0-2 -> outValid cycles 2-4, outSop+0xAABBCCDD at 2, outEop+0xDEADBEEF at 4, frameCount=1.
- Two 4-word frames back-to-back, IFG_CYCLES=3 -> exactly 3 outValid-low cycles between EOP and next SOP; frameCount=2.
- fifoEmpty forced high 2 cycles after 2nd word -> outValid low 2 cycles, no sop/eop, frame completes with correct data order.
- IDLE, FIFO word {0,0x12345678} -> no beat, errDrop pulse, following SOP frame transmitted normally.
- SOP word arrives while in XMIT -> errTrunc pulse, beat with outSop=1, frameCount unchanged until later EOP.
- reset=0 on 2nd beat of a frame -> all outputs 0 next cycle, state IDLE; after release, new frame transmits with frameCount=1.
